// File: rtl/apb_master_bridge_pkg.sv
// Shared state type and default sizes for the APB master bridge and its timeout counter.
package apb_pkg;

  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus signals of the bridge.
// master = bridge side; slave = local controller plus APB slave side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_bridge_timeout_ctr.sv
// ACCESS-phase wait counter; only built when APB_MASTER_TIMEOUT_EN is defined.
`ifdef APB_MASTER_TIMEOUT_EN
module apb_timeout_ctr import apb_pkg::*; #(
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] count;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  // Flags the edge on which this increment makes the count reach TIMEOUT_CYC.
  assign hit = enable && (count == LAST);

endmodule
`endif

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns valid/ready commands into SETUP/ACCESS transfers, one at a time.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYC cycles for pready.
module apb_master_bridge import apb_pkg::*; #(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_master_bridge_if.master  bus
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYC must be in 1..255");
  end

  apb_state_e        state;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              tmo_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .pclk   (pclk),
    .preset (preset),
    .clear  (state == SETUP),
    .enable (state == ACCESS && !bus.pready),
    .hit    (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // The response cycle is an ordinary IDLE cycle, so a new command can land on it.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            pwrite_q    <= bus.cmd_write;
            paddr_q     <= bus.cmd_addr;
            pwdata_q    <= bus.cmd_wdata;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end else if (tmo_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a memory-slave model and a response scoreboard.
// Covers the timeout path when APB_MASTER_TIMEOUT_EN is defined, unbounded waits otherwise.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TMO = 4;

  logic pclk   = 1'b0;
  logic preset = 1'b1;

  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  // Memory slave: pready rises once waitCfg ACCESS cycles have elapsed, unless forced low.
  logic [31:0] mem [0:63] = '{2: 32'h1234_5678, default: 32'h0};
  int accessCnt = 0;
  int waitCfg   = 0;
  bit forceLow  = 1'b0;

  assign bus.pready = !forceLow && (accessCnt >= waitCfg);
  assign bus.prdata = mem[bus.paddr[7:2]];

  always @(posedge pclk) begin
    if (bus.psel && bus.penable && !bus.pready) accessCnt <= accessCnt + 1;
    else accessCnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr[7:2]] <= bus.pwdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  int   passCount  = 0;
  int   failCount  = 0;
  int   totalCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Every response must match the oldest outstanding expectation.
  always @(negedge pclk) begin
    if (preset && bus.rsp_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("rsp_rdata", bus.rsp_rdata, monExp.rdata);
        checkOutput("rsp_err", {31'd0, bus.rsp_err}, {31'd0, monExp.err});
      end
    end
  end

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr);
    bit accepted = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (bus.cmd_ready) begin
        sbQ.push_back(exp_t'{expRdata, expErr});
        accepted = 1'b1;
        @(posedge pclk);
        #1;
      end else begin
        @(negedge pclk);
      end
    end
    bus.cmd_valid = 1'b0;
    checkOutput("cmd_accepted", {31'd0, accepted}, 32'd1);
  endtask

  task automatic runUntilRsp(input string tag, output int penCycles);
    bit seen = 1'b0;
    penCycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) seen = 1'b1;
      else if (bus.penable) penCycles++;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pen;
    bit sawRsp;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    // Reset state and first-edge cmd_ready
    #1 preset = 1'b0;
    @(negedge pclk);
    checkOutput("rst_ctrl", {26'd0, bus.cmd_ready, bus.psel, bus.penable, bus.rsp_valid,
                             bus.rsp_err, bus.pwrite}, 32'd0);
    checkOutput("rst_paddr", bus.paddr, 32'd0);
    checkOutput("rst_rdata", bus.rsp_rdata, 32'd0);
    #1 preset = 1'b1;
    #1 checkOutput("rdy_before_edge", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge pclk);
    checkOutput("rdy_after_edge", {31'd0, bus.cmd_ready}, 32'd1);

    // Write, zero wait
    $display("[TB] write zero-wait");
    waitCfg = 0;
    applyStimulus(1'b1, 32'h04, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge pclk);
    checkOutput("wr_setup_ctrl", {28'd0, bus.psel, bus.penable, bus.cmd_ready, bus.pwrite}, 32'b1001);
    checkOutput("wr_paddr", bus.paddr, 32'h04);
    checkOutput("wr_pwdata", bus.pwdata, 32'hDEAD_BEEF);
    @(negedge pclk);
    checkOutput("wr_access_ctrl", {30'd0, bus.psel, bus.penable}, 32'b11);
    @(negedge pclk);
    checkOutput("wr_rsp_ctrl", {28'd0, bus.rsp_valid, bus.psel, bus.penable, bus.cmd_ready}, 32'b1001);
    @(negedge pclk);
    checkOutput("wr_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("idle_paddr_hold", bus.paddr, 32'h04);

    // Read with two wait states
    $display("[TB] read two waits");
    waitCfg = 2;
    applyStimulus(1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0);
    runUntilRsp("rd_wait_rsp", pen);
    checkOutput("rd_wait_penable_cycles", pen, 32'd3);
    @(negedge pclk);
    checkOutput("rd_rdata_hold", bus.rsp_rdata, 32'h1234_5678);
    checkOutput("rd_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // Back-to-back: read issued in the write's response cycle
    $display("[TB] back-to-back");
    waitCfg = 0;
    applyStimulus(1'b1, 32'h10, 32'hA5A5_A5A5, 32'h0, 1'b0);
    runUntilRsp("b2b_wr_rsp", pen);
    applyStimulus(1'b0, 32'h10, 32'h0, 32'hA5A5_A5A5, 1'b0);
    @(negedge pclk);
    checkOutput("b2b_setup", {30'd0, bus.psel, bus.penable}, 32'b10);
    runUntilRsp("b2b_rd_rsp", pen);
    checkOutput("b2b_rd_penable_cycles", pen, 32'd1);

    // Asynchronous reset during ACCESS
    $display("[TB] async reset");
    @(negedge pclk);
    forceLow = 1'b1;
    applyStimulus(1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    @(negedge pclk);
    @(negedge pclk);
    checkOutput("pre_rst_access", {30'd0, bus.psel, bus.penable}, 32'b11);
    #2 preset = 1'b0;
    #1 checkOutput("async_rst_ctrl", {28'd0, bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid}, 32'd0);
    sbQ.delete();
    forceLow = 1'b0;
    @(negedge pclk);
    #1 preset = 1'b1;
    @(negedge pclk);
    checkOutput("rdy_after_release", {31'd0, bus.cmd_ready}, 32'd1);
    sawRsp = bus.rsp_valid;
    repeat (3) begin
      @(negedge pclk);
      sawRsp |= bus.rsp_valid;
    end
    checkOutput("no_rsp_after_reset", {31'd0, sawRsp}, 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
    $display("[TB] timeout abort");
    forceLow = 1'b1;
    applyStimulus(1'b0, 32'h08, 32'h0, 32'h0, 1'b1);
    runUntilRsp("tmo_rsp", pen);
    checkOutput("tmo_access_cycles", pen, TMO);
    @(negedge pclk);
    forceLow = 1'b0;
    waitCfg  = TMO - 1;
    applyStimulus(1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0);
    runUntilRsp("tmo_race_rsp", pen);
    checkOutput("tmo_race_access_cycles", pen, TMO);
`else
    $display("[TB] unbounded wait");
    forceLow = 1'b1;
    applyStimulus(1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0);
    sawRsp = 1'b0;
    repeat (3 * TMO) begin
      @(negedge pclk);
      sawRsp |= bus.rsp_valid;
    end
    checkOutput("unbounded_no_rsp", {31'd0, sawRsp}, 32'd0);
    checkOutput("unbounded_access", {30'd0, bus.psel, bus.penable}, 32'b11);
    forceLow = 1'b0;
    runUntilRsp("late_rsp", pen);
`endif

    @(negedge pclk);
    @(negedge pclk);
    checkOutput("sb_drained", sbQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
